// File: rtl/spi_mem_bridge.sv
// spi_mem_bridge: SPI mode-0 slave that turns host frames into one
// outstanding 32-bit memory request on the crossbar spi port.
// Ports: clk, rst (async, active-low); spi_sclk/spi_cs_n/spi_mosi in,
// spi_miso out; req_* request channel (val/rdy); resp_* response
// channel (val/rdy); busy = request outstanding.
module spi_mem_bridge #(
  parameter int p_opaq_bits   = 8,
  parameter int p_sync_stages = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   spi_sclk,
  input  logic                   spi_cs_n,
  input  logic                   spi_mosi,
  output logic                   spi_miso,
  output logic                   req_val,
  input  logic                   req_rdy,
  output logic                   req_op,
  output logic [p_opaq_bits-1:0] req_opaque,
  output logic [31:0]            req_addr,
  output logic [1:0]             req_len,
  output logic [31:0]            req_data,
  input  logic                   resp_val,
  output logic                   resp_rdy,
  input  logic                   resp_op,
  input  logic [p_opaq_bits-1:0] resp_opaque,
  input  logic [31:0]            resp_data,
  output logic                   busy
);

  localparam int LS = p_sync_stages - 1;
  localparam logic [7:0] CMD_RD = 8'h01;
  localparam logic [7:0] CMD_WR = 8'h02;
  localparam logic [7:0] CMD_RB = 8'h03;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT
  } state_t;

  state_t state_q, state_d;

  logic [LS:0] sclk_q;
  logic [LS:0] cs_q;
  logic [LS:0] mosi_q;
  logic        sclk_prev_q;
  logic        cs_prev_q;

  logic [6:0]  bit_q;
  logic [7:0]  cmd_q;
  logic [63:0] pay_q;
  logic [39:0] miso_q;

  logic                   req_op_q;
  logic [31:0]            req_addr_q;
  logic [31:0]            req_data_q;
  logic [p_opaq_bits-1:0] req_opq_q;
  logic [p_opaq_bits-1:0] tag_q;
  logic [31:0]            rdata_q;
  logic                   done_q;
  logic                   drop_q;
  logic                   ferr_q;
  logic                   etag_q;

  logic sclk_s, cs_s, mosi_s;
  logic sclk_rise, sclk_fall;
  logic cs_fall, cs_rise;
  logic is_rw, is_wr, is_rb, len_ok;
  logic idle;
  logic accept, drop, ferr, rb_clr;
  logic fire, resp_acc, mism;
  logic [7:0] status;

  // ---------------- pin synchronizers ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_q      <= '0;
      cs_q        <= '1;
      mosi_q      <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
    end else begin
      sclk_q      <= {sclk_q[LS-1:0], spi_sclk};
      cs_q        <= {cs_q[LS-1:0], spi_cs_n};
      mosi_q      <= {mosi_q[LS-1:0], spi_mosi};
      sclk_prev_q <= sclk_q[LS];
      cs_prev_q   <= cs_q[LS];
    end
  end

  assign sclk_s    = sclk_q[LS];
  assign cs_s      = cs_q[LS];
  assign mosi_s    = mosi_q[LS];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign cs_fall   = ~cs_s & cs_prev_q;
  assign cs_rise   = cs_s & ~cs_prev_q;

  assign idle   = (state_q == S_IDLE);
  assign busy   = ~idle;
  assign status = {busy, done_q, drop_q,
                   ferr_q, etag_q, 3'b000};

  // ---------------- frame shifter ----------------
  // MISO holds bit 39 through the command byte so the
  // 40 bits after the command carry status then rdata.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_q  <= '0;
      cmd_q  <= '0;
      pay_q  <= '0;
      miso_q <= '0;
    end else if (cs_fall) begin
      bit_q  <= '0;
      cmd_q  <= '0;
      pay_q  <= '0;
      miso_q <= {status, rdata_q};
    end else if (!cs_s) begin
      if (sclk_rise) begin
        if (bit_q != 7'd127)
          bit_q <= bit_q + 7'd1;
        if (bit_q < 7'd8)
          cmd_q <= {cmd_q[6:0], mosi_s};
        else if (bit_q < 7'd72)
          pay_q <= {pay_q[62:0], mosi_s};
      end
      if (sclk_fall && bit_q >= 7'd9)
        miso_q <= {miso_q[38:0], 1'b0};
    end
  end

  assign spi_miso = miso_q[39];

  // ---------------- frame decode ----------------
  always_comb begin
    is_rw  = 1'b0;
    is_wr  = 1'b0;
    is_rb  = 1'b0;
    len_ok = 1'b0;
    unique case (1'b1)
      cmd_q == CMD_RD: begin
        is_rw  = 1'b1;
        len_ok = (bit_q == 7'd40);
      end
      cmd_q == CMD_WR: begin
        is_rw  = 1'b1;
        is_wr  = 1'b1;
        len_ok = (bit_q == 7'd72);
      end
      cmd_q == CMD_RB: begin
        is_rb  = 1'b1;
        len_ok = (bit_q >= 7'd8);
      end
      default: ;
    endcase
  end

  // Unknown commands never set len_ok, so they land in ferr.
  assign accept = cs_rise & is_rw & len_ok & idle;
  assign drop   = cs_rise & is_rw & len_ok & ~idle;
  assign ferr   = cs_rise & ~len_ok;
  assign rb_clr = cs_rise & is_rb & len_ok;

  // ---------------- request FSM ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    req_val  = 1'b0;
    resp_rdy = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        req_val = 1'b1;
        if (req_rdy) state_d = S_WAIT;
      end
      S_WAIT: begin
        resp_rdy = 1'b1;
        if (resp_val) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign fire     = req_val & req_rdy;
  assign resp_acc = resp_rdy & resp_val;
  assign mism     = (resp_opaque != req_opq_q) |
                    (resp_op != req_op_q);

  // ---------------- request / status regs ----------------
  // Set beats the readback clear when both land together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_op_q   <= 1'b0;
      req_addr_q <= '0;
      req_data_q <= '0;
      req_opq_q  <= '0;
      tag_q      <= '0;
      rdata_q    <= '0;
      done_q     <= 1'b0;
      drop_q     <= 1'b0;
      ferr_q     <= 1'b0;
      etag_q     <= 1'b0;
    end else begin
      if (accept) begin
        req_op_q   <= is_wr;
        req_addr_q <= is_wr ? pay_q[63:32]
                            : pay_q[31:0];
        req_data_q <= is_wr ? pay_q[31:0] : '0;
        req_opq_q  <= tag_q;
      end
      if (fire)
        tag_q <= tag_q + p_opaq_bits'(1);
      if (resp_acc && !req_op_q)
        rdata_q <= resp_data;

      if (resp_acc)    done_q <= 1'b1;
      else if (rb_clr) done_q <= 1'b0;

      if (drop)        drop_q <= 1'b1;
      else if (rb_clr) drop_q <= 1'b0;

      if (ferr)        ferr_q <= 1'b1;
      else if (rb_clr) ferr_q <= 1'b0;

      if (resp_acc && mism) etag_q <= 1'b1;
      else if (rb_clr)      etag_q <= 1'b0;
    end
  end

  assign req_op     = req_op_q;
  assign req_addr   = req_addr_q;
  assign req_data   = req_data_q;
  assign req_opaque = req_opq_q;
  assign req_len    = 2'b00;

endmodule

// File: tb/tb_spi_mem_bridge.sv
// tb_spi_mem_bridge: drives SPI frames, emulates the memory port and
// compares against a transaction-level model of the bridge.
module tb_spi_mem_bridge;

  logic        clk      = 1'b0;
  logic        rst      = 1'b0;
  logic        spi_sclk = 1'b0;
  logic        spi_cs_n = 1'b1;
  logic        spi_mosi = 1'b0;
  logic        spi_miso;
  logic        req_val;
  logic        req_rdy;
  logic        req_op;
  logic [7:0]  req_opaque;
  logic [31:0] req_addr;
  logic [1:0]  req_len;
  logic [31:0] req_data;
  logic        resp_val;
  logic        resp_rdy;
  logic        resp_op;
  logic [7:0]  resp_opaque;
  logic [31:0] resp_data;
  logic        busy;

  always #5 clk = ~clk;

  spi_mem_bridge dut (
    .clk         (clk),
    .rst         (rst),
    .spi_sclk    (spi_sclk),
    .spi_cs_n    (spi_cs_n),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .req_val     (req_val),
    .req_rdy     (req_rdy),
    .req_op      (req_op),
    .req_opaque  (req_opaque),
    .req_addr    (req_addr),
    .req_len     (req_len),
    .req_data    (req_data),
    .resp_val    (resp_val),
    .resp_rdy    (resp_rdy),
    .resp_op     (resp_op),
    .resp_opaque (resp_opaque),
    .resp_data   (resp_data),
    .busy        (busy)
  );

  typedef struct {
    logic        op;
    logic [1:0]  len;
    logic [31:0] addr;
    logic [31:0] data;
    logic [7:0]  opq;
  } req_t;

  int errors = 0;
  int checks = 0;

  req_t fq[$];
  req_t xq[$];
  logic [31:0] mem     [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];

  bit hold    = 1'b0;
  bit resp_en = 1'b1;
  bit bad_tag = 1'b0;

  bit          m_busy, m_done, m_drop, m_frame, m_etag;
  logic [31:0] m_rdata;
  logic [7:0]  m_tag;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  function automatic logic [7:0] m_status();
    return {m_busy, m_done, m_drop,
            m_frame, m_etag, 3'b000};
  endfunction

  // memory port emulation
  initial begin
    req_t        f;
    logic [31:0] rd;
    req_rdy     = 1'b0;
    resp_val    = 1'b0;
    resp_op     = 1'b0;
    resp_opaque = '0;
    resp_data   = '0;
    forever begin
      @(negedge clk);
      req_rdy = ~hold;
      if (req_val && req_rdy) begin
        f.op   = req_op;
        f.len  = req_len;
        f.addr = req_addr;
        f.data = req_data;
        f.opq  = req_opaque;
        fq.push_back(f);
        if (resp_en) begin
          repeat ($urandom_range(1, 4)) @(negedge clk);
          if (f.op) begin
            mem[f.addr] = f.data;
            rd = $urandom;
          end else begin
            rd = mem.exists(f.addr) ? mem[f.addr] : 32'h0;
          end
          resp_op     = f.op;
          resp_opaque = f.opq;
          if (bad_tag) begin
            resp_opaque = f.opq + 8'd1;
            bad_tag     = 1'b0;
          end
          resp_data = rd;
          resp_val  = 1'b1;
          @(negedge clk);
          resp_val  = 1'b0;
        end
      end
    end
  end

  task automatic spi_frame(input logic [71:0] tx,
                           input int n,
                           output logic [39:0] rx);
    rx = '0;
    spi_cs_n = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      spi_mosi = tx[71-i];
      repeat (4) @(negedge clk);
      if (i >= 8 && i < 48)
        rx = {rx[38:0], spi_miso};
      spi_sclk = 1'b1;
      repeat (4) @(negedge clk);
      spi_sclk = 1'b0;
    end
    repeat (4) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic model_end(input logic [7:0] cmd,
                           input logic [31:0] a,
                           input logic [31:0] d,
                           input int n);
    req_t x;
    if (cmd == 8'h01 || cmd == 8'h02) begin
      if (n != ((cmd == 8'h02) ? 72 : 40)) begin
        m_frame = 1'b1;
      end else if (m_busy) begin
        m_drop = 1'b1;
      end else begin
        m_busy = 1'b1;
        x.op   = (cmd == 8'h02);
        x.len  = 2'b00;
        x.addr = a;
        x.data = x.op ? d : 32'h0;
        x.opq  = m_tag;
        xq.push_back(x);
      end
    end else if (cmd == 8'h03 && n >= 8) begin
      m_done  = 1'b0;
      m_drop  = 1'b0;
      m_frame = 1'b0;
      m_etag  = 1'b0;
    end else begin
      m_frame = 1'b1;
    end
  endtask

  task automatic send(input logic [7:0] cmd,
                      input logic [31:0] a,
                      input logic [31:0] d,
                      input int n);
    logic [71:0] tx;
    logic [39:0] rx;
    tx = {cmd, a, d};
    spi_frame(tx, n, rx);
    model_end(cmd, a, d, n);
  endtask

  task automatic readback(input string tag, input bit full);
    logic [7:0]  es;
    logic [31:0] er;
    logic [71:0] tx;
    logic [39:0] rx;
    int          n;
    es = m_status();
    er = m_rdata;
    n  = full ? 48 : 16;
    tx = {8'h03, 64'h0};
    spi_frame(tx, n, rx);
    model_end(8'h03, 32'h0, 32'h0, n);
    chk({tag, ".st"},
        64'(full ? rx[39:32] : rx[7:0]), 64'(es));
    if (full)
      chk({tag, ".rd"}, 64'(rx[31:0]), 64'(er));
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk({tag, ".timeout"}, 64'(n >= 300), 64'd0);
  endtask

  task automatic finish_txn(input string tag,
                            input bit bad,
                            output logic [7:0] obs);
    req_t f, x;
    obs = 8'h0;
    wait_idle(tag);
    chk({tag, ".fires"}, 64'(fq.size()), 64'd1);
    if (fq.size() > 0 && xq.size() > 0) begin
      f   = fq.pop_front();
      x   = xq.pop_front();
      obs = f.opq;
      chk({tag, ".op"},   64'(f.op),   64'(x.op));
      chk({tag, ".len"},  64'(f.len),  64'(x.len));
      chk({tag, ".addr"}, 64'(f.addr), 64'(x.addr));
      chk({tag, ".data"}, 64'(f.data), 64'(x.data));
      chk({tag, ".opq"},  64'(f.opq),  64'(x.opq));
      m_busy = 1'b0;
      m_done = 1'b1;
      if (bad) m_etag = 1'b1;
      if (x.op)
        ref_mem[x.addr] = x.data;
      else
        m_rdata = ref_mem.exists(x.addr) ?
                  ref_mem[x.addr] : 32'h0;
      m_tag = m_tag + 8'd1;
    end
  endtask

  task automatic model_reset();
    m_busy  = 1'b0;
    m_done  = 1'b0;
    m_drop  = 1'b0;
    m_frame = 1'b0;
    m_etag  = 1'b0;
    m_rdata = '0;
    m_tag   = '0;
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, d;
    logic [7:0]  obs, prev;
    bit          ok, saw_wrap;
    int          n, nrd;
    req_t        x;

    model_reset();
    repeat (3) @(negedge clk);
    chk("rst.miso",    64'(spi_miso),   64'd0);
    chk("rst.req_val", 64'(req_val),    64'd0);
    chk("rst.rdy",     64'(resp_rdy),   64'd0);
    chk("rst.busy",    64'(busy),       64'd0);
    chk("rst.fields",
        64'({req_op, req_opaque, req_len}), 64'd0);
    chk("rst.addr",    64'(req_addr),   64'd0);
    chk("rst.data",    64'(req_data),   64'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    send(8'h02, 32'h100, 32'hDEADBEEF, 72);
    finish_txn("wr0", 1'b0, obs);
    readback("wr0.rb", 1'b0);

    send(8'h01, 32'h100, 32'h0, 40);
    finish_txn("rd0", 1'b0, obs);
    readback("rd0.rb", 1'b1);
    readback("rd0.rb2", 1'b1);

    for (int i = 0; i < 2; i++) begin
      a = $urandom & 32'hFFFF_FFFC;
      d = $urandom;
      send(8'h02, a, d, 72);
      finish_txn("rnd.wr", 1'b0, obs);
      send(8'h01, a, 32'h0, 40);
      finish_txn("rnd.rd", 1'b0, obs);
      readback("rnd.rb", 1'b1);
    end

    hold = 1'b1;
    a = $urandom & 32'hFFFF_FFFC;
    d = $urandom;
    send(8'h02, a, d, 72);
    x  = xq[$];
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!(req_val === 1'b1 && req_op === 1'b1 &&
            req_addr === x.addr &&
            req_data === x.data &&
            req_opaque === x.opq))
        ok = 1'b0;
    end
    chk("stall.hold", 64'(ok), 64'd1);
    send(8'h02, $urandom, $urandom, 72);
    chk("stall.nofire", 64'(fq.size()), 64'd0);
    readback("stall.rb", 1'b0);
    hold = 1'b0;
    finish_txn("stall", 1'b0, obs);
    readback("stall.rb2", 1'b0);

    send(8'h01, $urandom, 32'h0, 35);
    chk("cut.nofire", 64'(fq.size()), 64'd0);
    chk("cut.busy",   64'(busy),      64'd0);
    readback("cut.rb", 1'b0);
    send(8'h7F, 32'h0, 32'h0, 8);
    readback("unk.rb", 1'b0);
    send(8'h03, 32'h0, 32'h0, 4);
    readback("rbshort.rb", 1'b0);

    nrd      = 257 - int'(m_tag);
    saw_wrap = 1'b0;
    prev     = 8'h0;
    for (int i = 0; i < nrd; i++) begin
      send(8'h01, $urandom & 32'hFFFF_FFFC, 32'h0, 40);
      finish_txn("wrap", 1'b0, obs);
      if (i > 0 && prev == 8'hFF && obs == 8'h00)
        saw_wrap = 1'b1;
      prev = obs;
    end
    chk("wrap.seen", 64'(saw_wrap), 64'd1);

    readback("pre_bad.rb", 1'b0);
    bad_tag = 1'b1;
    send(8'h02, $urandom & 32'hFFFF_FFFC, $urandom, 72);
    finish_txn("badtag", 1'b1, obs);
    readback("badtag.rb", 1'b1);

    resp_en = 1'b0;
    send(8'h01, $urandom & 32'hFFFF_FFFC, 32'h0, 40);
    n = 0;
    while (fq.size() == 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("mrst.fire", 64'(fq.size()), 64'd1);
    repeat (2) @(negedge clk);
    chk("mrst.wait_rdy", 64'(resp_rdy), 64'd1);
    rst = 1'b0;
    @(negedge clk);
    chk("mrst.busy",    64'(busy),     64'd0);
    chk("mrst.req_val", 64'(req_val),  64'd0);
    chk("mrst.rdy",     64'(resp_rdy), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    resp_op     = 1'b0;
    resp_opaque = 8'h0;
    resp_data   = $urandom;
    resp_val    = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("mrst.late_rdy", 64'(resp_rdy), 64'd0);
      chk("mrst.late_val", 64'(req_val),  64'd0);
    end
    resp_val = 1'b0;
    model_reset();
    fq.delete();
    xq.delete();
    resp_en = 1'b1;
    readback("mrst.rb", 1'b1);
    send(8'h02, $urandom & 32'hFFFF_FFFC, $urandom, 72);
    finish_txn("mrst.wr", 1'b0, obs);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
